l1_cache_core: RTL and testbench
================================

# l1_cache_core

Direct-mapped, write-back, write-allocate L1 cache storage and control. It sits directly downstream of the L1 word-to-line adapter. It consumes the adapter's replicated 256-bit write line and 32-bit byte-enable mask, and returns a full 256-bit read line for the adapter to slice. Misses are serviced over a 256-bit line-granular physical-memory port.

## Interface
- S_INDEX, default 4: index width; 2**S_INDEX sets. Tag width is 27 - S_INDEX; offset is fixed at 5 bits.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_address  in  32  CPU byte address. Bits [4:0] are ignored.
- mem_read  in  1  read request; held until mem_resp.
- mem_write  in  1  write request; held until mem_resp.
- mem_byte_enable_line  in  32  per-byte write mask for the line.
- mem_wdata_line  in  256  write line.
- mem_rdata_line  out  256  data-array line at the requested index.
- mem_resp  out  1  one-cycle completion pulse.
- pmem_address  out  32  line-aligned physical address; bits [4:0] are always 0.
- pmem_read  out  1  line fill request; held until pmem_resp.
- pmem_write  out  1  line writeback request; held until pmem_resp.
- pmem_wdata  out  256  victim line.
- pmem_rdata  in  256  fill line.
- pmem_resp  in  1  memory completion; valid for one cycle.

## Operation
- Per set: valid bit, dirty bit, tag, 256-bit line.
  - Valid and dirty reset to 0.
  - Tag and data are not reset.
- Field split: tag = mem_address[31:5+S_INDEX], index = mem_address[4+S_INDEX:5].
- hit = valid[index] && tag[index] == request tag. Arrays are read asynchronously.
- FSM states:
  - HIT_CHECK (reset state):
    - Idle when there is no request.
    - Read hit: mem_resp = 1; mem_rdata_line = data[index].
    - Write hit: mem_resp = 1. At the same edge, for each byte b with enable bit b set, data[index] byte b is replaced from mem_wdata_line; dirty[index] = 1.
    - Miss, victim clean or invalid: go to ALLOCATE.
    - Miss, victim valid and dirty: go to WRITEBACK.
  - WRITEBACK:
    - pmem_write = 1; pmem_address = {tag[index], index, 5'b0}; pmem_wdata = data[index].
    - On pmem_resp: dirty[index] = 0, go to ALLOCATE.
  - ALLOCATE:
    - pmem_read = 1; pmem_address = {request tag, index, 5'b0}.
    - On pmem_resp: data[index] = pmem_rdata, tag written, valid = 1, dirty = 0, go to HIT_CHECK.
    - The request then hits on the following cycle.
- mem_read and mem_write both high: treated as a write.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- Request withdrawn mid-miss (protocol violation): the in-flight pmem transaction still completes. The FSM returns to HIT_CHECK and mem_resp is never issued for the withdrawn request.

## Timing
- Reset values:
  - mem_resp = 0, pmem_read = 0, pmem_write = 0, state = HIT_CHECK.
  - pmem_address = line-aligned mem_address.
  - mem_rdata_line and pmem_wdata are unconstrained while their qualifiers are low.
- Hit: mem_resp is combinational, in the first cycle the request is present (0-cycle latency). The CPU must drop or change the request the cycle after mem_resp.
- Clean miss: mem_resp arrives L + 2 cycles after request, where L = pmem cycles from pmem_read high to pmem_resp.
- Dirty miss: adds the writeback latency plus 1 cycle.
- pmem_read and pmem_write are registered-state decodes: never both high, and each stays stable until pmem_resp.
- Reset asserted mid-miss: at that edge the FSM goes to HIT_CHECK, pmem strobes drop the next cycle, and valid/dirty clear. A pending pmem_resp after reset is ignored.

## Structure
- Package l1_cache_pkg holds:
  - Line width (256), offset width (5), byte-enable width (32).
  - State enum {HIT_CHECK, WRITEBACK, ALLOCATE}.
  - Tag/index extraction helpers.
- Sub-module l1_data_array: 2**S_INDEX x 256-bit flop array with async read and synchronous per-byte-masked write.
  - Written by both the CPU merge path and the fill path. Fill forces a full mask.
- Valid, dirty, tag arrays and the FSM live in l1_cache_core.

## Test plan
- Reset, then read 0x0000_0040: ALLOCATE with pmem_address 0x40; fill with 0xA5 pattern at L = 3; mem_resp 5 cycles after request with the 0xA5 line; a repeat read responds in 0 cycles.
- Write hit to 0x40, mask 0x0000_000F, wdata byte 0 = 0x11 replicated: only bytes 0–3 change; dirty[2] = 1; no pmem activity.
- Read 0x0000_0840 (same index 2, new tag): pmem_write at 0x40 with the merged line first, then pmem_read at 0x840; resp after both complete.
- Write miss to a clean set: fill, then merge; the returned line shows merged bytes, and dirty = 1.
- Assert rst during ALLOCATE: pmem_read drops after the edge; a late pmem_resp is ignored; a subsequent read to the same address misses again.
- mem_read and mem_write both high on a hit: data is written, dirty is set, one mem_resp.

Source files
------------

// File: rtl/l1_cache_pkg.sv
// rtl/l1_cache_pkg.sv - shared constants, FSM state type and address helpers for the L1 cache core
//
// Purpose: line/offset/byte-enable widths, the controller state enum and
// tag/index extraction helpers used by l1_cache_core and l1_data_array.
// Ports: none (package).
package l1_cache_pkg;

  localparam int LINE_W   = 256;
  localparam int OFFSET_W = 5;
  localparam int BE_W     = 32;

  typedef enum logic [1:0] {
    HIT_CHECK = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  // Helpers return a right-justified 32-bit field; callers slice to width.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int s_index);
    return addr >> (OFFSET_W + s_index);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] addr, input int s_index);
    return (addr >> OFFSET_W) & ((32'd1 << s_index) - 32'd1);
  endfunction

endpackage

// File: rtl/l1_data_array.sv
// rtl/l1_data_array.sv - 2**S_INDEX x 256-bit line store, async read, byte-masked sync write
//
// Purpose: data array shared by the CPU merge path and the line fill path.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   index  in   set index (read and write)
//   wmask  in   per-byte write mask (32)
//   wdata  in   write line (256)
//   rdata  out  line at index (combinational)
module l1_data_array
  import l1_cache_pkg::*;
#(
  parameter int S_INDEX = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [S_INDEX-1:0] index,
  input  logic [BE_W-1:0]    wmask,
  input  logic [LINE_W-1:0]  wdata,
  output logic [LINE_W-1:0]  rdata
);

  localparam int SETS = 1 << S_INDEX;

  logic [LINE_W-1:0] lines [SETS];

  assign rdata = lines[index];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wmask[b]) begin
          lines[index][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/l1_cache_core.sv
// rtl/l1_cache_core.sv - direct-mapped write-back write-allocate L1 cache storage and control
//
// Purpose: tag/valid/dirty arrays, hit detection and the miss FSM; line data
// lives in l1_data_array.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   mem_address (32)          CPU byte address, bits [4:0] ignored
//   mem_read, mem_write       CPU request strobes, held until mem_resp
//   mem_byte_enable_line (32) per-byte write mask
//   mem_wdata_line (256)      write line
//   mem_rdata_line (256)      line at the requested index
//   mem_resp                  one-cycle completion
//   pmem_address (32)         line-aligned physical address
//   pmem_read, pmem_write     fill / writeback strobes, held until pmem_resp
//   pmem_wdata (256)          victim line
//   pmem_rdata (256)          fill line
//   pmem_resp                 memory completion
module l1_cache_core
  import l1_cache_pkg::*;
#(
  parameter int S_INDEX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [BE_W-1:0]   mem_byte_enable_line,
  input  logic [LINE_W-1:0] mem_wdata_line,
  output logic [LINE_W-1:0] mem_rdata_line,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int TAG_W = 27 - S_INDEX;
  localparam int SETS  = 1 << S_INDEX;

  state_t state, next_state;

  logic [SETS-1:0]    valid, dirty;
  logic [TAG_W-1:0]   tags [SETS];

  logic [31:0]        tag_full, idx_full;
  logic [TAG_W-1:0]   req_tag;
  logic [S_INDEX-1:0] idx;
  logic               req, hit;
  logic               cpu_we, fill, wb_done;
  logic [LINE_W-1:0]  line;
  logic               unused_bits;

  assign tag_full    = addr_tag(mem_address, S_INDEX);
  assign idx_full    = addr_index(mem_address, S_INDEX);
  assign req_tag     = tag_full[TAG_W-1:0];
  assign idx         = idx_full[S_INDEX-1:0];
  assign unused_bits = ^{tag_full[31:TAG_W], idx_full[31:S_INDEX]};

  assign req = mem_read | mem_write;
  assign hit = valid[idx] && (tags[idx] == req_tag);

  assign mem_rdata_line = line;
  assign pmem_wdata     = line;

  always_comb begin
    next_state   = state;
    mem_resp     = 1'b0;
    cpu_we       = 1'b0;
    fill         = 1'b0;
    wb_done      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {mem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
    unique case (state)
      HIT_CHECK: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            // mem_write wins when both strobes are high
            cpu_we   = mem_write;
          end else if (valid[idx] && dirty[idx]) begin
            next_state = WRITEBACK;
          end else begin
            next_state = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tags[idx], idx, {OFFSET_W{1'b0}}};
        if (pmem_resp) begin
          wb_done    = 1'b1;
          // a withdrawn request abandons the fill after the writeback lands
          next_state = req ? ALLOCATE : HIT_CHECK;
        end
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          fill       = 1'b1;
          next_state = HIT_CHECK;
        end
      end
      default: next_state = HIT_CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HIT_CHECK;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= next_state;
      if (cpu_we)  dirty[idx] <= 1'b1;
      if (wb_done) dirty[idx] <= 1'b0;
      if (fill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && fill) begin
      tags[idx] <= req_tag;
    end
  end

  l1_data_array #(.S_INDEX(S_INDEX)) u_data (
    .clk   (clk),
    .we    (!rst && (cpu_we || fill)),
    .index (idx),
    .wmask (fill ? {BE_W{1'b1}} : mem_byte_enable_line),
    .wdata (fill ? pmem_rdata : mem_wdata_line),
    .rdata (line)
  );

endmodule

// File: tb/tb_l1_cache_core.sv
// tb/tb_l1_cache_core.sv - self-checking bench for l1_cache_core against a behavioural cache model
module tb_l1_cache_core;

  localparam int S_INDEX = 4;
  localparam int SETS    = 16;

  logic         clk, rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [31:0]  mem_byte_enable_line;
  logic [255:0] mem_wdata_line, mem_rdata_line;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  l1_cache_core #(.S_INDEX(S_INDEX)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .mem_address          (mem_address),
    .mem_read             (mem_read),
    .mem_write            (mem_write),
    .mem_byte_enable_line (mem_byte_enable_line),
    .mem_wdata_line       (mem_wdata_line),
    .mem_rdata_line       (mem_rdata_line),
    .mem_resp             (mem_resp),
    .pmem_address         (pmem_address),
    .pmem_read            (pmem_read),
    .pmem_write           (pmem_write),
    .pmem_wdata           (pmem_wdata),
    .pmem_rdata           (pmem_rdata),
    .pmem_resp            (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } op_t;

  // memory environment
  int           lat_l = 3;
  bit           auto_mem = 1'b1;
  logic         force_resp = 1'b0;
  op_t          seen_q[$];
  logic [255:0] pm [logic [31:0]];

  // reference cache model
  bit           m_valid [SETS];
  bit           m_dirty [SETS];
  logic [22:0]  m_tag   [SETS];
  logic [255:0] m_data  [SETS];
  logic [255:0] rm [logic [31:0]];

  function automatic logic [255:0] init_line(input logic [31:0] a);
    return {8{a ^ 32'h5EED_0000}};
  endfunction

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
  endtask

  // Physical memory: responds L cycles after its strobe is first seen.
  initial begin
    int  cnt;
    op_t o;
    cnt        = 0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (rst || !auto_mem) begin
        cnt       = 0;
        pmem_resp = force_resp;
      end else if (pmem_read || pmem_write) begin
        if (cnt == lat_l) begin
          o.wr   = pmem_write;
          o.addr = pmem_address;
          if (pmem_write) begin
            o.data = pmem_wdata;
            pm[pmem_address] = pmem_wdata;
          end else begin
            pmem_rdata = pm.exists(pmem_address) ? pm[pmem_address] : init_line(pmem_address);
            o.data     = pmem_rdata;
          end
          seen_q.push_back(o);
          pmem_resp = 1'b1;
          cnt       = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] be, input logic [255:0] wd,
                        input int l, input string name);
    logic [3:0]   idx;
    logic [22:0]  tg;
    logic [31:0]  la, victim;
    int           exp_lat, cyc;
    bit           done, both;
    logic [255:0] exp_rd;
    op_t          e;
    op_t          exp_ops[$];

    lat_l = l;
    idx   = a[8:5];
    tg    = a[31:9];
    la    = {a[31:5], 5'b0};
    if (m_valid[idx] && m_tag[idx] == tg) begin
      exp_lat = 0;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        victim = {m_tag[idx], idx, 5'b0};
        e.wr = 1'b1; e.addr = victim; e.data = m_data[idx];
        exp_ops.push_back(e);
        rm[victim] = m_data[idx];
        exp_lat = 2 * l + 3;
      end else begin
        exp_lat = l + 2;
      end
      m_data[idx] = rm.exists(la) ? rm[la] : init_line(la);
      e.wr = 1'b0; e.addr = la; e.data = m_data[idx];
      exp_ops.push_back(e);
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    exp_rd = m_data[idx];
    if (wr) begin
      for (int b = 0; b < 32; b++)
        if (be[b]) m_data[idx][8*b +: 8] = wd[8*b +: 8];
      m_dirty[idx] = 1'b1;
    end

    @(posedge clk); #1;
    seen_q.delete();
    mem_address          = a;
    mem_read             = rd;
    mem_write            = wr;
    mem_byte_enable_line = be;
    mem_wdata_line       = wd;
    cyc  = 0;
    done = 1'b0;
    both = 1'b0;
    while (!done && cyc <= 200) begin
      @(negedge clk);
      if (pmem_read && pmem_write) both = 1'b1;
      if (mem_resp) done = 1'b1;
      else cyc++;
    end
    chk({name, ":resp"}, 256'(done), 256'(1));
    chk({name, ":latency"}, 256'(cyc), 256'(exp_lat));
    chk({name, ":rdata"}, mem_rdata_line, exp_rd);
    chk({name, ":rd_wr_excl"}, 256'(both), 256'(0));
    chk({name, ":pmem_ops"}, 256'(seen_q.size()), 256'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < seen_q.size(); i++) begin
      chk({name, ":op_kind"}, 256'(seen_q[i].wr), 256'(exp_ops[i].wr));
      chk({name, ":op_addr"}, 256'(seen_q[i].addr), 256'(exp_ops[i].addr));
      chk({name, ":op_data"}, seen_q[i].data, exp_ops[i].data);
    end
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk({name, ":single_resp"}, 256'(mem_resp), 256'(0));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  ra, rbe;
    logic [255:0] rwd;
    bit           rrd, rwr;

    rst                  = 1'b1;
    mem_address          = 32'h0000_0123;
    mem_read             = 1'b0;
    mem_write            = 1'b0;
    mem_byte_enable_line = '0;
    mem_wdata_line       = '0;
    model_reset();
    pm[32'h40] = {32{8'hA5}};
    rm[32'h40] = {32{8'hA5}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset:mem_resp", 256'(mem_resp), 256'(0));
    chk("reset:pmem_read", 256'(pmem_read), 256'(0));
    chk("reset:pmem_write", 256'(pmem_write), 256'(0));
    chk("reset:pmem_address", 256'(pmem_address), 256'(32'h0000_0120));
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(32'h0000_0040, 1, 0, '0, '0, 3, "clean_miss");
    do_req(32'h0000_0040, 1, 0, '0, '0, 3, "read_hit");
    do_req(32'h0000_0040, 0, 1, 32'h0000_000F, {32{8'h11}}, 3, "write_hit");
    do_req(32'h0000_0040, 1, 0, '0, '0, 3, "read_merged");
    do_req(32'h0000_0840, 1, 0, '0, '0, 2, "dirty_miss");
    do_req(32'h0000_0060, 0, 1, 32'hF0F0_0001, {8{32'hDEAD_BEEF}}, 1, "write_miss");
    do_req(32'h0000_0060, 1, 0, '0, '0, 1, "write_miss_read");

    // reset while a fill is outstanding
    @(posedge clk); #1;
    lat_l       = 10;
    mem_address = 32'h0000_00C0;
    mem_read    = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_alloc:pmem_read_before", 256'(pmem_read), 256'(1));
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_read = 1'b0;
    auto_mem = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_alloc:pmem_read_after", 256'(pmem_read), 256'(0));
    chk("rst_alloc:pmem_write_after", 256'(pmem_write), 256'(0));
    chk("rst_alloc:mem_resp_after", 256'(mem_resp), 256'(0));
    pmem_rdata = {8{32'hBAD0_BAD0}};
    force_resp = 1'b1;
    @(negedge clk);
    force_resp = 1'b0;
    @(negedge clk);
    chk("late_resp:pmem_read", 256'(pmem_read), 256'(0));
    chk("late_resp:pmem_write", 256'(pmem_write), 256'(0));
    auto_mem = 1'b1;
    do_req(32'h0000_00C0, 1, 0, '0, '0, 2, "post_reset_miss");
    do_req(32'h0000_0040, 1, 0, '0, '0, 2, "post_reset_refill");

    do_req(32'h0000_0040, 1, 1, 32'h8000_0F00, {8{32'h1234_5678}}, 2, "rd_wr_hit");
    do_req(32'h0000_0040, 1, 0, '0, '0, 2, "rd_wr_readback");
    do_req(32'h0000_0840, 1, 0, '0, '0, 1, "rd_wr_evict");

    for (int i = 0; i < 40; i++) begin
      ra  = {23'($urandom_range(0, 2)), 4'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      rrd = 1'($urandom_range(0, 1));
      rwr = rrd ? 1'($urandom_range(0, 1)) : 1'b1;
      rbe = $urandom;
      for (int w = 0; w < 8; w++) rwd[32*w +: 32] = $urandom;
      do_req(ra, rrd, rwr, rbe, rwd, int'($urandom_range(0, 4)), $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
